alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 25 ++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcode constants, flag bit positions and FSM state type for the
// two-requester ALU arbiter.
package alu_arb_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    localparam int FL_NEG   = 3;
    localparam int FL_ZERO  = 2;
    localparam int FL_OVF   = 1;
    localparam int FL_CARRY = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU: op, a, b -> result, flags, err.
// Reserved opcode yields zero result, zero flags and err.
module alu_core
    import alu_arb_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic [3:0]  o_flags,
    output logic        o_err
);

    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_carry;
    logic        w_ovf;
    logic        w_err;

    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum   = {1'b0, i_a} + {1'b0, i_b};
                w_res   = w_sum[31:0];
                w_carry = w_sum[32];
                w_ovf   = (i_a[31] == i_b[31]) && (w_res[31] != i_a[31]);
            end
            OP_SUB: begin
                // carry set means no borrow
                w_sum   = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
                w_res   = w_sum[31:0];
                w_carry = w_sum[32];
                w_ovf   = (i_a[31] != i_b[31]) && (w_res[31] != i_a[31]);
            end
            OP_SLL: begin
                w_res = i_a << i_b[1:0];
                case (i_b[1:0])
                    2'd1:    w_carry = i_a[31];
                    2'd2:    w_carry = i_a[30];
                    2'd3:    w_carry = i_a[29];
                    default: w_carry = 1'b0;
                endcase
            end
            OP_SLTU: w_res = {31'd0, (i_a < i_b)};
            OP_XOR:  w_res = i_a ^ i_b;
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            default: w_err = 1'b1;
        endcase
    end

    assign o_result = w_res;
    assign o_err    = w_err;
    assign o_flags  = w_err ? 4'b0000 : {w_res[31], (w_res == 32'd0), w_ovf, w_carry};

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single ALU: IDLE -> EXEC -> RESP.
// Optional sticky status register enabled by ALU_ARB_STATUS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [2:0]  req_op_0,
    input  logic [2:0]  req_op_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
`ifdef ALU_ARB_STATUS_EN
    input  logic        status_clr,
    output logic [3:0]  status_flags,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err
);

    state_t      r_state, w_next;
    logic        r_last;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_id;
    logic        r_rsp_id;
    logic [31:0] r_result;
    logic [3:0]  r_flags;
    logic        r_err;

    logic        w_gnt_vld, w_gnt, w_accept;
    logic [31:0] w_result;
    logic [3:0]  w_flags;
    logic        w_err;

    // r_last holds the previous winner; ties go to the other requester
    always_comb begin
        w_gnt_vld = req_valid_0 | req_valid_1;
        if ((RR_EN != 0) && req_valid_0 && req_valid_1)
            w_gnt = ~r_last;
        else
            w_gnt = ~req_valid_0;
    end

    assign w_accept    = (r_state == ST_IDLE) && w_gnt_vld && !reset;
    assign req_ready_0 = w_accept && !w_gnt;
    assign req_ready_1 = w_accept &&  w_gnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    alu_core u_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_flags  (w_flags),
        .o_err    (w_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= 1'b0;
            r_rsp_id <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last <= w_gnt;
                r_id   <= w_gnt;
                r_op   <= w_gnt ? req_op_1 : req_op_0;
                r_a    <= w_gnt ? req_a_1  : req_a_0;
                r_b    <= w_gnt ? req_b_1  : req_b_0;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_id <= r_id;
                r_result <= w_result;
                r_flags  <= w_flags;
                r_err    <= w_err;
            end
        end
    end

    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_err    = r_err;

`ifdef ALU_ARB_STATUS_EN
    logic [3:0] r_status;

    always_ff @(posedge clk) begin
        if (reset || status_clr)
            r_status <= '0;
        else if (rsp_valid && rsp_ready)
            r_status <= r_status | r_flags;
    end

    assign status_flags = r_status;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: a round-robin and a
// fixed-priority instance share all inputs.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_0, req_valid_1;
    logic [2:0]  req_op_0, req_op_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic        rsp_ready;
    logic        status_clr;

    logic        rr_ready_0, rr_ready_1, rr_valid, rr_id, rr_err;
    logic [31:0] rr_result;
    logic [3:0]  rr_flags, rr_status;
    logic        fp_ready_0, fp_ready_1, fp_valid, fp_id, fp_err;
    logic [31:0] fp_result;
    logic [3:0]  fp_flags, fp_status;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1)) u_rr (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(rr_ready_0), .req_ready_1(rr_ready_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
`ifdef ALU_ARB_STATUS_EN
        .status_clr(status_clr), .status_flags(rr_status),
`endif
        .rsp_valid(rr_valid), .rsp_ready(rsp_ready), .rsp_id(rr_id),
        .rsp_result(rr_result), .rsp_flags(rr_flags), .rsp_err(rr_err)
    );

    alu_arbiter #(.RR_EN(0)) u_fp (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(fp_ready_0), .req_ready_1(fp_ready_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
`ifdef ALU_ARB_STATUS_EN
        .status_clr(status_clr), .status_flags(fp_status),
`endif
        .rsp_valid(fp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_id),
        .rsp_result(fp_result), .rsp_flags(fp_flags), .rsp_err(fp_err)
    );

`ifndef ALU_ARB_STATUS_EN
    assign rr_status = 4'h0;
    assign fp_status = 4'h0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on requester `id` (other requester idle), run to RESP.
    task automatic do_op(input logic id, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b;
        end else begin
            req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b;
        end
        #1;
        chk("ready_in_idle", {31'd0, id ? rr_ready_1 : rr_ready_0}, 32'd1);
        tick();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = 32'hDEAD_BEEF; req_a_1 = 32'hDEAD_BEEF;
        req_op_0 = 3'b110; req_op_1 = 3'b110;
        chk("exec_no_valid", {31'd0, rr_valid}, 32'd0);
        tick();
        chk("rsp_valid_n2", {31'd0, rr_valid}, 32'd1);
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [31:0] res,
                           input logic [3:0] fl, input logic err);
        chk({tag, "_id"},     {31'd0, rr_id}, {31'd0, id});
        chk({tag, "_result"}, rr_result, res);
        chk({tag, "_flags"},  {28'd0, rr_flags}, {28'd0, fl});
        chk({tag, "_err"},    {31'd0, rr_err}, {31'd0, err});
    endtask

    initial begin
        logic [31:0] rr_ids, fp_ids, rr_res;
        int nrsp, nfp;

        reset = 1'b1; rsp_ready = 1'b0; status_clr = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        req_op_0 = '0; req_op_1 = '0;
        req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
        tick(); tick();
        chk("rst_valid",  {31'd0, rr_valid}, 32'd0);
        chk("rst_ready",  {30'd0, rr_ready_1, rr_ready_0}, 32'd0);
        chk("rst_result", rr_result, 32'd0);
        chk("rst_misc",   {26'd0, rr_id, rr_err, rr_flags}, 32'd0);
        chk("rst_status", {28'd0, rr_status}, 32'd0);
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        reset = 1'b0;
        tick();

        // ADD overflow with a 5-cycle stall on rsp_ready
        do_op(1'b0, 3'b000, 32'h7FFF_FFFF, 32'd1);
        chk_rsp("add", 1'b0, 32'h8000_0000, 4'b1010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid",  {31'd0, rr_valid}, 32'd1);
            chk("stall_result", rr_result, 32'h8000_0000);
            chk("stall_flags",  {28'd0, rr_flags}, 32'hA);
            chk("stall_ready",  {30'd0, rr_ready_1, rr_ready_0}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("hs_idle", {31'd0, rr_valid}, 32'd0);

        do_op(1'b1, 3'b001, 32'd5, 32'd5);
        chk_rsp("sub", 1'b1, 32'd0, 4'b0101, 1'b0);
        tick();
        do_op(1'b0, 3'b010, 32'h8000_0001, 32'd1);
        chk_rsp("sll", 1'b0, 32'h0000_0002, 4'b0001, 1'b0);
        tick();
        do_op(1'b0, 3'b011, 32'd1, 32'd2);
        chk_rsp("sltu", 1'b0, 32'd1, 4'b0000, 1'b0);
        tick();
        do_op(1'b1, 3'b100, 32'hFF00_FF00, 32'h0FF0_0FF0);
        chk_rsp("xor", 1'b1, 32'hF0F0_F0F0, 4'b1000, 1'b0);
        tick();
        do_op(1'b0, 3'b101, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        chk_rsp("and", 1'b0, 32'd0, 4'b0100, 1'b0);
        tick();
        do_op(1'b0, 3'b111, 32'h1234_5678, 32'h9);
        chk_rsp("rsv", 1'b0, 32'd0, 4'b0000, 1'b1);
        tick();

        // Both requesters valid every cycle after a fresh reset
        reset = 1'b1; tick(); reset = 1'b0;
        req_valid_0 = 1'b1; req_op_0 = 3'b000; req_a_0 = 32'd10; req_b_0 = 32'd1;
        req_valid_1 = 1'b1; req_op_1 = 3'b000; req_a_1 = 32'd20; req_b_1 = 32'd1;
        rr_ids = '0; fp_ids = '0; rr_res = '0; nrsp = 0; nfp = 0;
        for (int c = 0; c < 40 && nrsp < 4; c++) begin
            tick();
            if (fp_valid && nfp < 4) begin
                fp_ids[nfp] = fp_id;
                nfp++;
            end
            if (rr_valid) begin
                rr_ids[nrsp] = rr_id;
                if (nrsp == 1) rr_res = rr_result;
                nrsp++;
            end
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        chk("rr_count",  nrsp, 32'd4);
        chk("rr_ids",    rr_ids, 32'b1010);
        chk("rr_res1",   rr_res, 32'd21);
        chk("fp_count",  nfp, 32'd4);
        chk("fp_ids",    fp_ids, 32'b0000);
        tick(); tick(); tick();

        // Reset while holding a response discards it
        rsp_ready = 1'b0;
        do_op(1'b1, 3'b000, 32'd3, 32'd4);
        reset = 1'b1;
        tick();
        chk("rst_resp_valid", {31'd0, rr_valid}, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rr_valid) nrsp++;
        end
        chk("no_rsp_after_rst", nrsp, 32'd0);

`ifdef ALU_ARB_STATUS_EN
        do_op(1'b0, 3'b000, 32'hFFFF_FFFF, 32'd2);
        chk_rsp("add_c", 1'b0, 32'd1, 4'b0001, 1'b0);
        tick();
        do_op(1'b0, 3'b011, 32'd1, 32'd2);
        tick();
        chk("status_or", {28'd0, rr_status}, 32'b0001);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("status_clr", {28'd0, rr_status}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
